// File: rtl/multdiv_wb_ctrl_pkg.sv
// Shared constants and types for the multiply/divide writeback controller:
// decode fields, exception defaults and FSM/op encodings.
package multdiv_wb_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 7;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  localparam int unsigned DEF_RSTATUS_REG  = 30;
  localparam int unsigned DEF_MUL_EXC_CODE = 4;
  localparam int unsigned DEF_DIV_EXC_CODE = 5;
  localparam int unsigned DEF_TIMEOUT      = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    WRITE = 2'd3
  } md_state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_e;

endpackage

// File: rtl/md_cycle_counter.sv
// Saturating BUSY-cycle counter with synchronous clear and a terminal-count flag
// used as the multdiv timeout.
module md_cycle_counter
  import multdiv_wb_ctrl_pkg::*;
#(
  parameter int unsigned TERMINAL = DEF_TIMEOUT - 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Holds at all-ones instead of wrapping so a stuck unit can never re-arm the timeout.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == CNT_W'(TERMINAL));

endmodule

// File: rtl/multdiv_wb_ctrl.sv
// Sequences a multi-cycle mul/div: stalls the pipe, starts the unit, waits for
// the result (or times out) and issues a deferred regfile write.
module multdiv_wb_ctrl
  import multdiv_wb_ctrl_pkg::*;
#(
  parameter int unsigned RSTATUS_REG  = DEF_RSTATUS_REG,
  parameter int unsigned MUL_EXC_CODE = DEF_MUL_EXC_CODE,
  parameter int unsigned DIV_EXC_CODE = DEF_DIV_EXC_CODE,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [XLEN-1:0]  in_instr,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  operandA,
  input  logic [XLEN-1:0]  operandB,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic [XLEN-1:0]  md_operandA,
  output logic [XLEN-1:0]  md_operandB,
  input  logic [XLEN-1:0]  md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  input  logic             pipe_wb_active,
  output logic             stall,
  output logic             wb_enable,
  output logic [REG_W-1:0] wb_reg,
  output logic [XLEN-1:0]  wb_data
);

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]  opa_q, opa_d;
  logic [XLEN-1:0]  opb_q, opb_d;
  logic             mul_q, mul_d;
  logic             div_q, div_d;
  logic [REG_W-1:0] wb_reg_q, wb_reg_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             wb_pend_q, wb_pend_d;

  logic is_mul, is_div, accept;
  logic cnt_clr, cnt_en, cnt_tc;
  logic done_exc;
  logic instr_unused;

  assign is_mul = (in_instr[31:27] == OPC_RTYPE) && (in_instr[6:2] == ALUOP_MUL);
  assign is_div = (in_instr[31:27] == OPC_RTYPE) && (in_instr[6:2] == ALUOP_DIV);
  assign accept = (state_q == IDLE) && in_valid && (is_mul || is_div);
  assign instr_unused = ^{in_instr[21:7], in_instr[1:0]};

  md_cycle_counter #(
    .TERMINAL (TIMEOUT - 1)
  ) u_cycle_counter (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (cnt_clr),
    .enable_i (cnt_en),
    .tc_o     (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    mul_d     = 1'b0;
    div_d     = 1'b0;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    wb_pend_d = wb_pend_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    done_exc  = 1'b0;
    wb_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          op_d    = is_div ? OP_DIV : OP_MUL;
          rd_d    = in_instr[26:22];
          opa_d   = operandA;
          opb_d   = operandB;
          mul_d   = is_mul;
          div_d   = is_div;
        end
      end
      START: begin
        cnt_clr = 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        cnt_en = 1'b1;
        // A timeout without RDY is reported exactly like a unit exception.
        if (md_resultRDY || cnt_tc) begin
          done_exc  = !md_resultRDY || md_exception;
          wb_reg_d  = done_exc ? REG_W'(RSTATUS_REG) : rd_q;
          wb_data_d = !done_exc ? md_result
                    : (op_q == OP_DIV) ? XLEN'(DIV_EXC_CODE) : XLEN'(MUL_EXC_CODE);
          wb_pend_d = done_exc || (rd_q != '0);
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (!pipe_wb_active) begin
          wb_enable = wb_pend_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      rd_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      mul_q     <= 1'b0;
      div_q     <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
      wb_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      mul_q     <= mul_d;
      div_q     <= div_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      wb_pend_q <= wb_pend_d;
    end
  end

  // Stall covers the accept cycle too, so it must follow in_valid combinationally.
  assign stall       = reset && ((state_q != IDLE) || accept);
  assign ctrl_MULT   = mul_q;
  assign ctrl_DIV    = div_q;
  assign md_operandA = opa_q;
  assign md_operandB = opb_q;
  assign wb_reg      = wb_reg_q;
  assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_multdiv_wb_ctrl.sv
// Scoreboard bench for multdiv_wb_ctrl: expected writebacks are queued at issue
// and compared against writes observed on the regfile port.
module tb_multdiv_wb_ctrl;

  localparam int unsigned TIMEOUT = 64;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wb_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_valid = 1'b0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] md_operandA, md_operandB;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_resultRDY = 1'b0;
  logic        pipe_wb_active = 1'b0;
  logic        stall, wb_enable;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_mul   = 0;
  int  n_div   = 0;
  int  n_wb    = 0;
  wb_t sb[$];
  wb_t obs[$];

  multdiv_wb_ctrl #(
    .RSTATUS_REG  (30),
    .MUL_EXC_CODE (4),
    .DIV_EXC_CODE (5),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_instr       (in_instr),
    .in_valid       (in_valid),
    .operandA       (operandA),
    .operandB       (operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .md_operandA    (md_operandA),
    .md_operandB    (md_operandB),
    .md_result      (md_result),
    .md_exception   (md_exception),
    .md_resultRDY   (md_resultRDY),
    .pipe_wb_active (pipe_wb_active),
    .stall          (stall),
    .wb_enable      (wb_enable),
    .wb_reg         (wb_reg),
    .wb_data        (wb_data)
  );

  always #5 clock = ~clock;

  // Observe start pulses and regfile writes away from the active edge.
  always @(negedge clock) begin
    wb_t o;
    if (ctrl_MULT) n_mul++;
    if (ctrl_DIV)  n_div++;
    if (wb_enable) begin
      n_wb++;
      o.r = wb_reg;
      o.d = wb_data;
      obs.push_back(o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mk_instr(input bit div, input logic [4:0] rd);
    logic [31:0] ins;
    ins        = 32'h0;
    ins[26:22] = rd;
    ins[21:17] = 5'd2;
    ins[6:2]   = div ? 5'b00111 : 5'b00110;
    return ins;
  endfunction

  // rdy_after: cycles after START that RDY arrives (<0 means never, forcing timeout).
  task automatic do_op(input string tag, input bit div, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input int rdy_after,
                       input logic [31:0] res, input bit exc, input int hold, input bit spam);
    int  lat, m0, d0, w0;
    bit  exc_eff, we;
    wb_t e, o, x;
    exc_eff = exc || (rdy_after < 0);
    we      = exc_eff || (rd != 5'd0);
    e.r     = exc_eff ? 5'd30 : rd;
    e.d     = exc_eff ? (div ? 32'd5 : 32'd4) : res;
    if (we) sb.push_back(e);
    lat = (rdy_after < 0) ? int'(TIMEOUT) : rdy_after;
    m0 = n_mul; d0 = n_div; w0 = n_wb;

    in_valid = 1'b1; in_instr = mk_instr(div, rd); operandA = a; operandB = b;
    #1 chk({tag, ":stall_accept"}, 32'(stall), 32'd1);
    tick();
    in_valid = spam; operandA = ~a; operandB = ~b;
    chk({tag, ":ctrl_mult_start"}, 32'(ctrl_MULT), 32'(!div));
    chk({tag, ":ctrl_div_start"}, 32'(ctrl_DIV), 32'(div));
    for (int i = 0; i < lat; i++) begin
      tick();
      if (i == 0) chk({tag, ":ctrl_one_cycle"}, 32'(ctrl_MULT | ctrl_DIV), 32'd0);
      if (i == lat - 1 && rdy_after >= 0) begin
        md_resultRDY = 1'b1; md_result = res; md_exception = exc;
      end
    end
    tick();
    md_resultRDY = 1'b0; md_exception = 1'b0; md_result = 32'hBAD0_BAD0; in_valid = 1'b0;
    chk({tag, ":md_operandA"}, md_operandA, a);
    chk({tag, ":md_operandB"}, md_operandB, b);
    for (int h = 0; h < hold; h++) begin
      pipe_wb_active = 1'b1;
      #1 chk({tag, ":wb_held"}, 32'(wb_enable), 32'd0);
      chk({tag, ":stall_held"}, 32'(stall), 32'd1);
      if (we) chk({tag, ":data_held"}, wb_data, e.d);
      tick();
    end
    pipe_wb_active = 1'b0;
    #1 chk({tag, ":wb_enable_latency"}, 32'(wb_enable), 32'(we));
    chk({tag, ":stall_write"}, 32'(stall), 32'd1);
    tick();
    chk({tag, ":stall_after"}, 32'(stall), 32'd0);
    chk({tag, ":mult_pulses"}, 32'(n_mul - m0), 32'(!div));
    chk({tag, ":div_pulses"}, 32'(n_div - d0), 32'(div));
    chk({tag, ":wb_count"}, 32'(n_wb - w0), 32'(we));
    if (we && obs.size() > 0 && sb.size() > 0) begin
      o = obs.pop_front();
      x = sb.pop_front();
      chk({tag, ":wb_reg"}, 32'(o.r), 32'(x.r));
      chk({tag, ":wb_data"}, o.d, x.d);
    end
    sb.delete();
    obs.delete();
  endtask

  initial begin
    int w0;
    // Reset holds everything low even with a valid mul presented.
    reset = 1'b0; in_valid = 1'b1; in_instr = mk_instr(1'b0, 5'd5);
    operandA = 32'd9; operandB = 32'd9;
    tick(); tick();
    chk("rst:stall", 32'(stall), 32'd0);
    chk("rst:wb_enable", 32'(wb_enable), 32'd0);
    chk("rst:ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    chk("rst:wb_reg", 32'(wb_reg), 32'd0);
    chk("rst:wb_data", wb_data, 32'd0);
    chk("rst:md_opA", md_operandA, 32'd0);
    chk("rst:md_opB", md_operandB, 32'd0);
    reset = 1'b1; in_valid = 1'b0;
    tick();

    do_op("mul5",    1'b0, 5'd5,  32'd6,    32'd7, 3,  32'd42,        1'b0, 0, 1'b0);
    do_op("div3exc", 1'b1, 5'd3,  32'd10,   32'd0, 2,  32'd0,         1'b1, 0, 1'b0);
    do_op("mul_rd0", 1'b0, 5'd0,  32'd3,    32'd4, 1,  32'd12,        1'b0, 0, 1'b0);
    do_op("hold2",   1'b0, 5'd12, 32'd77,   32'd3, 2,  32'hDEAD_BEEF, 1'b0, 2, 1'b0);
    do_op("timeout", 1'b0, 5'd8,  32'd5,    32'd5, -1, 32'd0,         1'b0, 0, 1'b0);
    do_op("spam",    1'b1, 5'd17, 32'd1000, 32'd8, 4,  32'd125,       1'b0, 0, 1'b1);
    do_op("exc_rd0", 1'b0, 5'd0,  32'hFFFF, 32'hFFFF, 1, 32'd0,       1'b1, 1, 1'b0);

    // Reset while BUSY: abandon the op and ignore a late RDY.
    w0 = n_wb;
    in_valid = 1'b1; in_instr = mk_instr(1'b0, 5'd9); operandA = 32'd3; operandB = 32'd5;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("midrst:stall", 32'(stall), 32'd0);
    chk("midrst:wb_enable", 32'(wb_enable), 32'd0);
    chk("midrst:md_opA", md_operandA, 32'd0);
    chk("midrst:wb_reg", 32'(wb_reg), 32'd0);
    reset = 1'b1; md_resultRDY = 1'b1; md_result = 32'd15;
    #1 chk("midrst:stall_rel", 32'(stall), 32'd0);
    tick();
    md_resultRDY = 1'b0;
    chk("midrst:late_rdy_wb", 32'(wb_enable), 32'd0);
    chk("midrst:late_rdy_stall", 32'(stall), 32'd0);
    tick();
    chk("midrst:no_write", 32'(n_wb - w0), 32'd0);
    obs.delete();
    do_op("post_rst_div", 1'b1, 5'd7, 32'd100, 32'd7, 1, 32'd14, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_wb_ctrl.md
MULTDIV_WB_CTRL -- requirements
Module: multdiv_wb_ctrl

Interface
REQ-001 SHALL have parameter RSTATUS_REG, default 30, register written on exception.
REQ-002 SHALL have parameter MUL_EXC_CODE, default 4, rstatus value on mul exception.
REQ-003 SHALL have parameter DIV_EXC_CODE, default 5, rstatus value on div exception.
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum BUSY cycles before a forced exception.
REQ-005 SHALL have port clock  in  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  in  1  reset, synchronous and active-low.
REQ-007 SHALL have port in_instr  in  32  instruction in the execute stage.
REQ-008 SHALL have port in_valid  in  1  in_instr is valid this cycle.
REQ-009 SHALL have port operandA / operandB  in  32 each  register operands rs and rt.
REQ-010 SHALL have port ctrl_MULT / ctrl_DIV  out  1 each  start pulses to the multdiv unit.
REQ-011 SHALL have port md_operandA / md_operandB  out  32 each  latched operands to multdiv.
REQ-012 SHALL have port md_result  in  32  multdiv result.
REQ-013 SHALL have port md_exception  in  1  multdiv overflow or divide-by-zero.
REQ-014 SHALL have port md_resultRDY  in  1  multdiv result valid.
REQ-015 SHALL have port pipe_wb_active  in  1  the normal pipeline writes the regfile this cycle (it has priority).
REQ-016 SHALL have port stall  out  1  freeze fetch, decode and execute.
REQ-017 SHALL have ports wb_enable  out  1, wb_reg  out  5, and wb_data  out  32  deferred regfile write.

Function
REQ-018 SHALL decode mul as in_instr[31:27]=00000 with [6:2]=00110, and div as [31:27]=00000 with [6:2]=00111.
REQ-019 SHALL use states IDLE, START, BUSY, WRITE.
REQ-020 IDLE: in_valid & (mul|div) in cycle T SHALL latch rd=in_instr[26:22], op, operandA and operandB, go to START, and assert stall combinationally in cycle T.
REQ-021 START (T+1): SHALL pulse ctrl_MULT or ctrl_DIV, per op, high for exactly one cycle, clear the cycle counter, and go to BUSY.
REQ-022 BUSY: SHALL sample md_resultRDY only in BUSY; on RDY it SHALL capture md_result and md_exception and go to WRITE.
REQ-023 BUSY: SHALL count cycles; if the counter reaches TIMEOUT-1 without RDY, it SHALL force exception=1 and go to WRITE.
REQ-024 WRITE with pipe_wb_active=1: SHALL hold with wb_enable=0.
REQ-025 WRITE with pipe_wb_active=0: SHALL assert wb_enable for one cycle, then go to IDLE.
REQ-026 On exception, the write SHALL use wb_reg=RSTATUS_REG and wb_data=MUL_EXC_CODE or DIV_EXC_CODE per op; otherwise wb_reg=rd and wb_data=result.
REQ-027 No exception with rd=0: wb_enable SHALL stay 0, and WRITE SHALL still return to IDLE.
REQ-028 stall SHALL be high in START, BUSY and WRITE (including the write cycle), and low the cycle after the write.
REQ-029 in_valid SHALL be ignored outside IDLE; no second operation is queued.
REQ-030 md_operandA and md_operandB SHALL hold the latched values from START until IDLE.
REQ-031 Minimum latency: RDY at cycle T+k (k>=2) SHALL give wb_enable at T+k+1 when pipe_wb_active=0.
REQ-032 The cycle counter SHALL be 7 bits and SHALL saturate, never wrapping.

Reset
REQ-033 reset=0 at a rising edge SHALL force IDLE, clear the counter and latches, and drive ctrl_MULT, ctrl_DIV, stall, wb_enable=0 and wb_reg, wb_data, md_operandA, md_operandB=0.
REQ-034 Reset mid-operation SHALL abandon the operation with no write issued, and a late md_resultRDY after reset SHALL be ignored.
REQ-035 The cycle after reset releases, the block SHALL accept a new mul/div.

Structure
REQ-036 The shared package SHALL hold the opcode/ALU-op codes for mul and div, RSTATUS_REG, the exception codes, and the state encoding.
REQ-037 One sub-module, md_cycle_counter (clear, enable, saturate, terminal-count flag), SHALL implement the timeout counter; everything else SHALL be flat.

Verification
REQ-038 The bench SHALL cover: mul rd=5, A=6, B=7, RDY 3 cycles after START -> single ctrl_MULT pulse, wb_enable with wb_reg=5, wb_data=42, stall low the next cycle.
REQ-039 The bench SHALL cover: div rd=3, A=10, B=0, RDY with exception -> wb_reg=30, wb_data=5, and no write to r3.
REQ-040 The bench SHALL cover: mul rd=0, no exception -> wb_enable never asserted, and the FSM returns to IDLE.
REQ-041 The bench SHALL cover: RDY present while pipe_wb_active=1 for 2 cycles -> wb_enable delayed exactly 2 cycles, with data unchanged.
REQ-042 The bench SHALL cover: no RDY for TIMEOUT cycles on mul -> wb_reg=30, wb_data=4.
REQ-043 The bench SHALL cover: reset=0 in BUSY, then RDY -> no wb_enable, stall=0, and a subsequent div completes normally.
